// File: rtl/ocd_gen.sv
// ocd_gen: qualified overcurrent flag generator.
// Synchronises the comparator and the drive reference, blanks the comparator
// around drive edges, filters it, stretches each trip to a minimum hold time,
// counts trips per window and latches a lockout when a window sees too many.
// Build option: define OCD_STICKY_EN to make every trip latch straight into
// lockout (HOLD is then never entered).
//
// state | meaning
// IDLE  | no fault, ocd=0, waiting for a filtered trip
// HOLD  | trip being stretched, ocd=1 until hold expires and cmp_s is low
// LOCK  | too many trips (or sticky trip), ocd=1 and lock=1 until clr
module ocd_gen #(
  parameter int FILT_CNT  = 4,
  parameter int BLANK_CYC = 10,
  parameter int HOLD_CYC  = 200,
  parameter int TRIP_MAX  = 8,
  parameter int WIN_CYC   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmp,
  input  logic       gen,
  input  logic       clr,
  output logic       ocd,
  output logic       lock,
  output logic [7:0] trip_cnt
);

  localparam int QW = ($clog2(FILT_CNT + 1) < 1) ? 1 : $clog2(FILT_CNT + 1);
  localparam int BW = ($clog2(BLANK_CYC + 1) < 1) ? 1 : $clog2(BLANK_CYC + 1);
  localparam int HW = ($clog2(HOLD_CYC) < 1) ? 1 : $clog2(HOLD_CYC);
  localparam int WW = ($clog2(WIN_CYC) < 1) ? 1 : $clog2(WIN_CYC);

  localparam logic [QW-1:0] FILT_V  = QW'(FILT_CNT);
  localparam logic [BW-1:0] BLANK_V = BW'(BLANK_CYC);
  localparam logic [HW-1:0] HOLD_V  = HW'(HOLD_CYC - 1);
  localparam logic [WW-1:0] WIN_V   = WW'(WIN_CYC - 1);
`ifndef OCD_STICKY_EN
  localparam logic [7:0]    TRIP_V  = 8'(TRIP_MAX);
`endif

  typedef enum logic [1:0] {IDLE, HOLD, LOCK} state_t;

  logic cmp_m_q, cmp_s_q;
  logic gen_m_q, gen_s_q, gen_d1_q;

  state_t        state_q, state_d;
  logic [QW-1:0] qual_q, qual_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] win_q, win_d;
  logic [7:0]    trip_q, trip_d;
  logic          ocd_q, ocd_d;
  logic          lock_q, lock_d;

  logic       gen_edge;
  logic       blanked;
  logic       hit;
  logic       win_reload;
  logic [7:0] trip_base;
  logic [7:0] trip_inc;

  // Two-flop synchronisers for both async inputs, plus the gen_s edge delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_m_q  <= 1'b0;
      cmp_s_q  <= 1'b0;
      gen_m_q  <= 1'b0;
      gen_s_q  <= 1'b0;
      gen_d1_q <= 1'b0;
    end else begin
      cmp_m_q  <= cmp;
      cmp_s_q  <= cmp_m_q;
      gen_m_q  <= gen;
      gen_s_q  <= gen_m_q;
      gen_d1_q <= gen_s_q;
    end
  end

  // Next-state logic: blanking, qualifier, window, trip counting and FSM.
  always_comb begin
    gen_edge   = gen_s_q ^ gen_d1_q;
    blanked    = (blank_q != '0);
    hit        = (qual_q == FILT_V);
    win_reload = (win_q == '0);
    // A window reload clears the count before this cycle's trip is added,
    // except in lockout where the count is frozen for inspection.
    trip_base  = (win_reload && state_q != LOCK) ? 8'd0 : trip_q;
    trip_inc   = (trip_base == 8'hFF) ? trip_base : trip_base + 8'd1;

    state_d = state_q;
    trip_d  = trip_base;
    blank_d = gen_edge ? BLANK_V : (blanked ? blank_q - BW'(1) : '0);
    win_d   = win_reload ? WIN_V : win_q - WW'(1);
    hold_d  = (hold_q != '0) ? hold_q - HW'(1) : '0;
    if (cmp_s_q && !blanked) begin
      qual_d = hit ? qual_q : qual_q + QW'(1);
    end else begin
      qual_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (hit) begin
          trip_d = trip_inc;
          hold_d = HOLD_V;
`ifdef OCD_STICKY_EN
          state_d = LOCK;
`else
          state_d = (trip_inc >= TRIP_V) ? LOCK : HOLD;
`endif
        end
      end
      HOLD: begin
        // Hold only ends once the comparator has also released, so a
        // persistent fault keeps ocd asserted without counting new trips.
        if (hold_q == '0 && !cmp_s_q) begin
          state_d = IDLE;
          qual_d  = '0;
        end
      end
      LOCK: begin
        if (clr) begin
          state_d = IDLE;
          trip_d  = 8'd0;
          qual_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    ocd_d  = (state_d != IDLE);
    lock_d = (state_d == LOCK);
  end

  // Register all controller state and the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      qual_q  <= '0;
      blank_q <= '0;
      hold_q  <= '0;
      win_q   <= WIN_V;
      trip_q  <= 8'd0;
      ocd_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
      blank_q <= blank_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
      trip_q  <= trip_d;
      ocd_q   <= ocd_d;
      lock_q  <= lock_d;
    end
  end

  assign ocd      = ocd_q;
  assign lock     = lock_q;
  assign trip_cnt = trip_q;

endmodule

// File: tb/tb_ocd_gen.sv
// Bench for ocd_gen: directed scenarios plus a random phase, all checked
// cycle by cycle against a behavioural model built from raw-sample history.
module tb_ocd_gen;

  localparam int P_FILT  = 4;
  localparam int P_BLANK = 10;
  localparam int P_HOLD  = 200;
  localparam int P_TRIP  = 3;
  localparam int P_WIN   = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmp = 1'b0;
  logic       gen = 1'b0;
  logic       clr = 1'b0;
  logic       ocd;
  logic       lock;
  logic [7:0] trip_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ocd_gen #(
    .FILT_CNT (P_FILT),
    .BLANK_CYC(P_BLANK),
    .HOLD_CYC (P_HOLD),
    .TRIP_MAX (P_TRIP),
    .WIN_CYC  (P_WIN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmp     (cmp),
    .gen     (gen),
    .clr     (clr),
    .ocd     (ocd),
    .lock    (lock),
    .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  // Raw input values seen at each clock edge since reset (index = edge number).
  int cmp_h[$];
  int gen_h[$];
  int m_u;          // edges since reset release
  int m_mode;       // 0 no fault, 1 stretching, 2 locked out
  int m_qual;       // consecutive unblanked high synchronised samples
  int m_trip;
  int m_entry;      // edge at which the current stretch began
  int m_last_load;  // edge at which blanking was last (re)started

  function automatic int hc(int i);
    return (i >= 1 && i < cmp_h.size()) ? cmp_h[i] : 0;
  endfunction

  function automatic int hg(int i);
    return (i >= 1 && i < gen_h.size()) ? gen_h[i] : 0;
  endfunction

  task automatic model_reset();
    m_u = 0; m_mode = 0; m_qual = 0; m_trip = 0; m_entry = 0;
    m_last_load = -1000000;
    cmp_h.delete(); gen_h.delete();
    cmp_h.push_back(0); gen_h.push_back(0);
  endtask

  task automatic model_edge(input int c, input int g, input int k);
    int cs, nq, nmode, ntrip, base;
    bit blanked, load, hit, reload;
    m_u++;
    cmp_h.push_back(c);
    gen_h.push_back(g);
    // synchronised comparator seen before this edge is the raw value two edges back
    cs      = hc(m_u - 2);
    blanked = (m_u - 1 - m_last_load) < P_BLANK;
    load    = hg(m_u - 2) != hg(m_u - 3);
    hit     = (m_qual == P_FILT);
    nq      = (cs != 0 && !blanked) ? ((m_qual + 1 > P_FILT) ? P_FILT : m_qual + 1) : 0;
    reload  = (m_u % P_WIN) == 0;
    base    = (reload && m_mode != 2) ? 0 : m_trip;
    nmode   = m_mode;
    ntrip   = base;
    if (m_mode == 0) begin
      if (hit) begin
        ntrip   = (base + 1 > 255) ? 255 : base + 1;
        m_entry = m_u;
`ifdef OCD_STICKY_EN
        nmode = 2;
`else
        nmode = (ntrip >= P_TRIP) ? 2 : 1;
`endif
      end
    end else if (m_mode == 1) begin
      if ((m_u - 1 - m_entry) >= P_HOLD - 1 && cs == 0) begin
        nmode = 0;
        nq    = 0;
      end
    end else begin
      if (k != 0) begin
        nmode = 0;
        ntrip = 0;
        nq    = 0;
      end
    end
    m_mode = nmode;
    m_trip = ntrip;
    m_qual = nq;
    if (load) m_last_load = m_u;
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; drives inputs, lets one rising edge pass and checks.
  task automatic tick(input logic c, input logic g, input logic k);
    cmp = c; gen = g; clr = k;
    @(posedge clk);
    #1;
    model_edge(int'(c), int'(g), int'(k));
    chk("ocd", 32'(ocd), 32'(m_mode != 0));
    chk("lock", 32'(lock), 32'(m_mode == 2));
    chk("trip_cnt", 32'(trip_cnt), 32'(m_trip));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmp = 1'b0; gen = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic one_trip();
    for (int i = 1; i <= 300; i++) tick(i <= 10, 1'b0, 1'b0);
  endtask

  initial begin
    int rise, fall, seen, last_tog, glen, burst, lvl;
    logic g;

    model_reset();
    @(negedge clk);
    #1;
    chk("reset_ocd", 32'(ocd), 0);
    chk("reset_lock", 32'(lock), 0);
    chk("reset_trip", 32'(trip_cnt), 0);

    // Glitch rejection: fewer than FILT_CNT samples high
    do_reset();
    glen = $urandom_range(1, P_FILT - 1);
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(i <= glen, 1'b0, 1'b0);
      if (ocd) seen = 1;
    end
    chk("glitch_ocd", 32'(seen), 0);
    chk("glitch_trip", 32'(trip_cnt), 0);

    // Trip and minimum hold
    do_reset();
    rise = -1; fall = -1;
    for (int i = 1; i <= 260; i++) begin
      tick(i <= 10, 1'b0, 1'b0);
      if (ocd && rise < 0) rise = i;
      if (!ocd && rise >= 0 && fall < 0) fall = i;
    end
    chk("trip_latency", 32'(rise), 32'(P_FILT + 3));
    chk("trip_cnt_one", 32'(trip_cnt), 1);
`ifndef OCD_STICKY_EN
    chk("hold_len", 32'(fall - rise), 32'(P_HOLD));
`else
    chk("sticky_lock", 32'(lock), 1);
`endif

    // Hold extension while the comparator stays high
    do_reset();
    rise = -1; fall = -1;
    for (int i = 1; i <= 520; i++) begin
      tick(i <= 500, 1'b0, 1'b0);
      if (ocd && rise < 0) rise = i;
      if (!ocd && rise >= 0 && fall < 0) fall = i;
    end
`ifndef OCD_STICKY_EN
    chk("ext_fall", 32'(fall), 32'(500 + 3));
`else
    chk("ext_sticky", 32'(ocd), 1);
`endif

    // Blanking: gen toggling faster than the blank window hides cmp entirely
    do_reset();
    g = 1'b0; seen = 0; last_tog = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i % 8 == 0) begin
        g = ~g;
        last_tog = i;
      end
      tick(i > 16, g, 1'b0);
      if (ocd) seen = 1;
    end
    chk("blank_no_trip", 32'(seen), 0);
    rise = -1;
    for (int j = 1; j <= 40; j++) begin
      tick(1'b1, g, 1'b0);
      if (ocd && rise < 0) rise = 100 - last_tog + j;
    end
    chk("blank_release", 32'(rise), 32'(2 + P_BLANK + P_FILT + 1));

    // Lockout after TRIP_MAX trips, frozen across a window reload, then clear
    do_reset();
    for (int t = 0; t < 3; t++) one_trip();
    chk("lock_set", 32'(lock), 1);
    chk("lock_ocd", 32'(ocd), 1);
    for (int i = 0; i < 4500; i++) tick(1'b0, 1'b0, 1'b0);
`ifndef OCD_STICKY_EN
    chk("lock_frozen", 32'(trip_cnt), 32'(P_TRIP));
`else
    chk("lock_frozen", 32'(trip_cnt), 1);
`endif
    chk("lock_held", 32'(lock), 1);
    tick(1'b0, 1'b0, 1'b1);
    chk("clr_lock", 32'(lock), 0);
    chk("clr_ocd", 32'(ocd), 0);
    chk("clr_trip", 32'(trip_cnt), 0);

    // Window reload clears the trip count
    do_reset();
    one_trip();
`ifdef OCD_STICKY_EN
    chk("sticky_first", 32'(lock), 1);
`endif
    one_trip();
    for (int i = 0; i < 2500; i++) tick(1'b0, 1'b0, 1'b0);
`ifndef OCD_STICKY_EN
    chk("win_clear", 32'(trip_cnt), 0);
    one_trip();
    chk("win_third_cnt", 32'(trip_cnt), 1);
    chk("win_third_nolock", 32'(lock), 0);
`endif

    // Asynchronous reset in the middle of a stretched trip
    do_reset();
    for (int i = 1; i <= 60; i++) tick(i <= 10, 1'b0, 1'b0);
    chk("pre_rst_ocd", 32'(ocd), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ocd", 32'(ocd), 0);
    chk("arst_lock", 32'(lock), 0);
    chk("arst_trip", 32'(trip_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Random phase: comparator bursts, drive toggles and stray clears
    do_reset();
    g = 1'b0; burst = 0; lvl = 0;
    for (int i = 0; i < 8000; i++) begin
      if (burst == 0) begin
        lvl   = (lvl == 0) ? 1 : 0;
        burst = (lvl != 0) ? $urandom_range(1, 40) : $urandom_range(1, 400);
      end
      burst--;
      if ($urandom_range(0, 49) == 0) g = ~g;
      tick(lvl != 0, g, $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
